// File: rtl/mem_store_sequencer.sv
// Store-button sequencer for the 4-byte latch memory.
// Debounces the button and drives a glitch-free setup/strobe/hold write.
module mem_store_sequencer #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 2,
  parameter int SCAN_CYC     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic [7:0] data_in,
  input  logic       scan,
  output logic [7:0] data,
  output logic [1:0] addr,
  output logic       store,
  output logic       busy,
  output logic [7:0] wr_count
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RELEASE,
    SCAN
  } state_e;

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] SCAN_LAST   = 8'(SCAN_CYC - 1);

  logic           btn_meta_q, btn_sync_q;
  logic           scan_meta_q, scan_sync_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           btn_db_q, btn_db_d;
  logic           press_q, press_d;
  state_e         state_q, state_d;
  logic [7:0]     tmr_q, tmr_d;
  logic [7:0]     data_q, data_d;
  logic [1:0]     addr_q, addr_d;
  logic           store_q, store_d;
  logic           busy_q, busy_d;
  logic [7:0]     wr_count_q, wr_count_d;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      scan_meta_q <= 1'b0;
      scan_sync_q <= 1'b0;
    end else begin
      btn_meta_q  <= btn_raw;
      btn_sync_q  <= btn_meta_q;
      scan_meta_q <= scan;
      scan_sync_q <= scan_meta_q;
    end
  end

  // Debounce: flip only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    press_d  = 1'b0;
    if (btn_sync_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = ~btn_db_q;
        press_d  = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Sequencer next state; store/busy are registered from the next state.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wr_count_d = wr_count_q;
    unique case (state_q)
      IDLE: begin
        if (scan_sync_q) begin
          state_d = SCAN;
          tmr_d   = '0;
        end else if (press_q) begin
          state_d = SETUP;
          tmr_d   = '0;
          data_d  = data_in;
        end
      end
      SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = STROBE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      STROBE: begin
        if (tmr_q == STROBE_LAST) begin
          state_d = HOLD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d    = RELEASE;
          tmr_d      = '0;
          addr_d     = addr_q + 2'd1;
          wr_count_d = wr_count_q + 8'd1;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      RELEASE: begin
        if (!btn_db_q) state_d = IDLE;
      end
      SCAN: begin
        if (!scan_sync_q) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == SCAN_LAST) begin
          tmr_d  = '0;
          addr_d = addr_q + 2'd1;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    store_d = (state_d == STROBE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q   <= '0;
      btn_db_q   <= 1'b0;
      press_q    <= 1'b0;
      state_q    <= IDLE;
      tmr_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      store_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      btn_db_q   <= btn_db_d;
      press_q    <= press_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign data     = data_q;
  assign addr     = addr_q;
  assign store    = store_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_store_sequencer.sv
// Directed bench for mem_store_sequencer.
// Scenario tasks compare against hand-computed values.
module tb_mem_store_sequencer;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic [7:0] data_in;
  logic       scan;
  logic [7:0] data;
  logic [1:0] addr;
  logic       store;
  logic       busy;
  logic [7:0] wr_count;

  int vecs = 0;
  int errs = 0;

  int         store_cnt = 0;
  int         width = 0;
  int         width_bad = 0;
  int         glitch = 0;
  logic [1:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic       p_store = 0;
  logic [1:0] p_addr = '0;
  logic [7:0] p_data = '0;
  logic [7:0] mem [4];

  mem_store_sequencer #(
    .DEBOUNCE_CYC(4),
    .SETUP_CYC(2),
    .STROBE_CYC(2),
    .HOLD_CYC(2),
    .SCAN_CYC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .data_in(data_in),
    .scan(scan),
    .data(data),
    .addr(addr),
    .store(store),
    .busy(busy),
    .wr_count(wr_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Store-pulse observer and behavioural model of the latch memory.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_store = 0;
      p_addr  = addr;
      p_data  = data;
      width   = 0;
    end else begin
      if (store && !p_store) begin
        store_cnt++;
        last_addr = addr;
        last_data = data;
        width = 1;
      end else if (store) begin
        width++;
      end
      if (!store && p_store && width != 2) width_bad++;
      if ((store || p_store) && (addr !== p_addr || data !== p_data))
        glitch++;
      if (store) mem[addr] = data;
      p_store = store;
      p_addr  = addr;
      p_data  = data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < 300) begin
      tick(1);
      c++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic wait_store(output bit ok);
    int c = 0;
    while (store !== 1'b1 && c < 60) begin
      tick(1);
      c++;
    end
    ok = (store === 1'b1);
  endtask

  task automatic press_write(input logic [7:0] d, input int hold,
                             output bit ok);
    data_in = d;
    btn_raw = 1;
    tick(hold);
    btn_raw = 0;
    wait_idle(ok);
    tick(2);
  endtask

  task automatic do_reset();
    rst_n   = 0;
    btn_raw = 0;
    scan    = 0;
    tick(3);
    rst_n = 1;
    tick(2);
  endtask

  task automatic test_reset();
    rst_n   = 0;
    btn_raw = 0;
    scan    = 0;
    data_in = 8'h00;
    tick(3);
    vecs++;
    if ({data, addr, store, busy, wr_count} !== 20'h0) begin
      errs++;
      $display("FAIL reset: data=%h addr=%0d store=%b busy=%b wr=%0d want 0",
               data, addr, store, busy, wr_count);
    end
    rst_n = 1;
    tick(2);
  endtask

  task automatic test_clean_write();
    int s0 = store_cnt;
    bit ok;
    data_in = 8'hA5;
    btn_raw = 1;
    tick(20);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL clean_busy_held: busy=%b want 1", busy);
    end
    btn_raw = 0;
    wait_idle(ok);
    tick(2);
    vecs++;
    if (!ok || busy !== 1'b0) begin
      errs++;
      $display("FAIL clean_idle: busy=%b want 0", busy);
    end
    vecs++;
    if (store_cnt - s0 != 1 || width_bad != 0) begin
      errs++;
      $display("FAIL clean_pulse: pulses=%0d bad_width=%0d want 1/0",
               store_cnt - s0, width_bad);
    end
    vecs++;
    if (last_addr !== 2'd0 || last_data !== 8'hA5 || mem[0] !== 8'hA5) begin
      errs++;
      $display("FAIL clean_wdata: addr=%0d data=%h mem0=%h want 0/a5/a5",
               last_addr, last_data, mem[0]);
    end
    vecs++;
    if (addr !== 2'd1 || wr_count !== 8'd1) begin
      errs++;
      $display("FAIL clean_after: addr=%0d wr=%0d want 1/1", addr, wr_count);
    end
  endtask

  task automatic test_bounce();
    int s0 = store_cnt;
    bit ok;
    data_in = 8'h3C;
    btn_raw = 1;
    tick(1);
    btn_raw = 0;
    tick(1);
    btn_raw = 1;
    tick(1);
    vecs++;
    if (store_cnt != s0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL bounce_toggle: pulses=%0d busy=%b want 0/0",
               store_cnt - s0, busy);
    end
    tick(20);
    btn_raw = 0;
    wait_idle(ok);
    tick(2);
    vecs++;
    if (!ok || store_cnt - s0 != 1 || last_addr !== 2'd1 ||
        last_data !== 8'h3C) begin
      errs++;
      $display("FAIL bounce_write: pulses=%0d addr=%0d data=%h want 1/1/3c",
               store_cnt - s0, last_addr, last_data);
    end
    s0 = store_cnt;
    data_in = 8'hE7;
    for (int w = 1; w <= 3; w++) begin
      btn_raw = 1;
      tick(w);
      btn_raw = 0;
      tick(8);
    end
    vecs++;
    if (store_cnt != s0 || wr_count !== 8'd2 || addr !== 2'd2) begin
      errs++;
      $display("FAIL bounce_short: pulses=%0d wr=%0d addr=%0d want 0/2/2",
               store_cnt - s0, wr_count, addr);
    end
  endtask

  task automatic test_wrap_held();
    logic [7:0] dv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int s0;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press_write(dv[i], 20, ok);
      vecs++;
      if (!ok || last_addr !== 2'(i) || last_data !== dv[i]) begin
        errs++;
        $display("FAIL wrap_w%0d: addr=%0d data=%h want %0d/%h",
                 i, last_addr, last_data, i, dv[i]);
      end
    end
    vecs++;
    if (addr !== 2'd0 || wr_count !== 8'd4) begin
      errs++;
      $display("FAIL wrap_end: addr=%0d wr=%0d want 0/4", addr, wr_count);
    end
    s0 = store_cnt;
    data_in = 8'h66;
    btn_raw = 1;
    tick(150);
    vecs++;
    if (busy !== 1'b1 || wr_count !== 8'd5) begin
      errs++;
      $display("FAIL held_mid: busy=%b wr=%0d want 1/5", busy, wr_count);
    end
    tick(50);
    btn_raw = 0;
    wait_idle(ok);
    tick(2);
    vecs++;
    if (!ok || store_cnt - s0 != 1 || wr_count !== 8'd5 || addr !== 2'd1) begin
      errs++;
      $display("FAIL held_once: pulses=%0d wr=%0d addr=%0d want 1/5/1",
               store_cnt - s0, wr_count, addr);
    end
  endtask

  task automatic test_data_freeze();
    bit ok;
    data_in = 8'h5A;
    btn_raw = 1;
    wait_store(ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL freeze_strobe: store=%b want 1 (timeout)", store);
    end
    data_in = 8'hFF;
    tick(1);
    vecs++;
    if (store !== 1'b1 || data !== 8'h5A) begin
      errs++;
      $display("FAIL freeze_in_strobe: store=%b data=%h want 1/5a",
               store, data);
    end
    tick(1);
    vecs++;
    if (store !== 1'b0 || data !== 8'h5A) begin
      errs++;
      $display("FAIL freeze_in_hold: store=%b data=%h want 0/5a",
               store, data);
    end
    tick(15);
    btn_raw = 0;
    wait_idle(ok);
    tick(2);
    vecs++;
    if (!ok || last_addr !== 2'd1 || mem[1] !== 8'h5A || data !== 8'h5A) begin
      errs++;
      $display("FAIL freeze_mem: addr=%0d mem1=%h data=%h want 1/5a/5a",
               last_addr, mem[1], data);
    end
  endtask

  task automatic test_scan();
    int s0;
    int c;
    bit ok;
    logic [1:0] prev;
    do_reset();
    s0 = store_cnt;
    scan = 1;
    c = 0;
    while (busy !== 1'b1 && c < 20) begin
      tick(1);
      c++;
    end
    vecs++;
    if (busy !== 1'b1 || addr !== 2'd0) begin
      errs++;
      $display("FAIL scan_enter: busy=%b addr=%0d want 1/0", busy, addr);
    end
    data_in = 8'hC3;
    btn_raw = 1;
    for (int k = 1; k <= 5; k++) begin
      prev = addr;
      c = 0;
      while (addr === prev && c < 20) begin
        tick(1);
        c++;
      end
      vecs++;
      if (c != 8 || addr !== 2'(k % 4)) begin
        errs++;
        $display("FAIL scan_step%0d: gap=%0d addr=%0d want 8/%0d",
                 k, c, addr, k % 4);
      end
      if (k == 1) btn_raw = 0;
    end
    scan = 0;
    wait_idle(ok);
    vecs++;
    if (!ok || addr !== 2'd1) begin
      errs++;
      $display("FAIL scan_exit: busy=%b addr=%0d want 0/1", busy, addr);
    end
    tick(20);
    vecs++;
    if (busy !== 1'b0 || addr !== 2'd1 || store_cnt != s0 ||
        wr_count !== 8'd0) begin
      errs++;
      $display("FAIL scan_noq: busy=%b addr=%0d pulses=%0d wr=%0d want 0/1/0/0",
               busy, addr, store_cnt - s0, wr_count);
    end
  endtask

  task automatic test_reset_mid_strobe();
    bit ok;
    press_write(8'h42, 20, ok);
    vecs++;
    if (!ok || last_addr !== 2'd1 || wr_count !== 8'd1 || addr !== 2'd2) begin
      errs++;
      $display("FAIL rst_pre: addr_w=%0d wr=%0d addr=%0d want 1/1/2",
               last_addr, wr_count, addr);
    end
    data_in = 8'h77;
    btn_raw = 1;
    wait_store(ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL rst_strobe: store=%b want 1 (timeout)", store);
    end
    #2;
    rst_n = 0;
    btn_raw = 0;
    #1;
    vecs++;
    if (store !== 1'b0 || addr !== 2'd0 || wr_count !== 8'd0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_async: store=%b addr=%0d wr=%0d busy=%b want 0",
               store, addr, wr_count, busy);
    end
    #4;
    rst_n = 1;
    tick(2);
    press_write(8'h99, 20, ok);
    vecs++;
    if (!ok || last_addr !== 2'd0 || last_data !== 8'h99 ||
        wr_count !== 8'd1 || addr !== 2'd1) begin
      errs++;
      $display("FAIL rst_next: addr_w=%0d data=%h wr=%0d addr=%0d want 0/99/1/1",
               last_addr, last_data, wr_count, addr);
    end
    vecs++;
    if (glitch != 0 || width_bad != 0) begin
      errs++;
      $display("FAIL glitch_rule: glitches=%0d bad_widths=%0d want 0/0",
               glitch, width_bad);
    end
  endtask

  initial begin
    test_reset();
    test_clean_write();
    test_bounce();
    test_wrap_held();
    test_data_freeze();
    test_scan();
    test_reset_mid_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_store_sequencer.md
Name: mem_store_sequencer

Overview:
- Write-side controller for the 4-byte latch memory.
- Turns a raw, bouncy store button into a safe write sequence: address/data set up, single store strobe, hold, then address auto-increment.
- Also provides a scan mode that steps the address so the memory output can be read back on the LEDs.
- Sits between board switches/button and the memory's data/store/addr inputs. It replaces the direct wiring of the store button to the latch enable.

Parameters:
- DEBOUNCE_CYC, 16, consecutive stable synchronized samples required to accept a button level change.
- SETUP_CYC, 2, cycles data/addr are driven before store rises.
- STROBE_CYC, 2, cycles store is held high.
- HOLD_CYC, 2, cycles data/addr are held after store falls.
- SCAN_CYC, 8, cycles per address step in scan mode.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- btn_raw  input  1  asynchronous store button, active-high, bouncy.
- data_in  input  8  byte from switches.
- scan  input  1  1 = readback scan mode, 0 = write mode; synchronized internally.
- data  output  8  byte to memory data input.
- addr  output  2  address to memory.
- store  output  1  memory latch enable.
- busy  output  1  high whenever the FSM is not in IDLE.
- wr_count  output  8  number of completed writes, wraps at 255 -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous): data=0, addr=0, store=0, busy=0, wr_count=0, FSM=IDLE, debounced button=0, scan timer=0.
- Reset release: all state leaves reset on the first clk edge after rst_n goes high.
- Input sync: btn_raw and scan each pass through 2 flops before use.
- Debounce:
  - A counter counts cycles where the synced button differs from the debounced level; it resets to 0 on any agreement.
  - When the count reaches DEBOUNCE_CYC, the debounced level flips.
  - A rising edge of the debounced level is a press event. It lasts exactly 1 cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, RELEASE, SCAN.
  - IDLE: store=0.
    - Synced scan=1 -> SCAN.
    - Press event with scan=0 -> SETUP. Capture data_in into data on the same edge; data stays frozen until HOLD ends.
  - SETUP: store=0 for SETUP_CYC cycles -> STROBE.
  - STROBE: store=1 for exactly STROBE_CYC cycles; addr and data stay stable -> HOLD.
  - HOLD: store=0 for HOLD_CYC cycles. On exit: addr = addr+1 (mod 4, so 3 wraps to 0), wr_count+1 -> RELEASE.
  - RELEASE: wait until the debounced button is 0 -> IDLE. A held button never causes a second write.
  - SCAN: store forced 0. addr increments mod 4 every SCAN_CYC cycles. Synced scan=0 -> IDLE, with addr left at its current value.
- Glitch rule: store changes only while addr and data are stable. addr and data never change in the cycle store is 1, nor in the cycle store falls.
- Simultaneous events: a scan rise during SETUP/STROBE/HOLD is ignored until the sequence completes and reaches IDLE. A press in SCAN is ignored, not queued.
- Press events outside IDLE are dropped.
- busy=1 in every state except IDLE.
- All outputs are registered; no combinational path from any input to any output.
- Reset mid-STROBE: store drops asynchronously. The interrupted write does not count (wr_count=0) and addr returns to 0.

Test Plan (bench overrides DEBOUNCE_CYC=4, SETUP_CYC=2, STROBE_CYC=2, HOLD_CYC=2, SCAN_CYC=8):
- Clean write:
  - Stimulus: rst_n low then high, data_in=8'hA5, btn_raw high for 20 cycles then low.
  - Required: exactly one store pulse 2 cycles wide with data=A5, addr=0 throughout; addr becomes 1 after HOLD; wr_count=1; busy back to 0 after the button is released.
- Bounce rejection:
  - Stimulus: btn_raw toggles every cycle for 3 cycles, then high.
  - Required: no store during the toggling; exactly one store after 4 stable cycles.
  - Stimulus: pulses of 1–3 cycles only.
  - Required: zero stores.
- Wrap and held button:
  - Stimulus: 4 separate presses with data 11, 22, 33, 44.
  - Required: writes at addr 0, 1, 2, 3; addr wraps to 0; wr_count=4.
  - Stimulus: a single press held for 200 cycles.
  - Required: only 1 write.
- Data freeze:
  - Stimulus: data_in changed from 5A to FF during STROBE.
  - Required: data stays 5A until HOLD exits; memory at that address reads 5A.
- Scan mode:
  - Stimulus: scan=1 from IDLE.
  - Required: addr sequence 0, 1, 2, 3, 0 at 8-cycle spacing; store stays 0; a press during scan produces no store.
  - Stimulus: scan=0.
  - Required: FSM returns to IDLE with addr held.
- Async reset mid-strobe:
  - Stimulus: rst_n low for half a cycle while store=1.
  - Required: store=0 immediately without a clock edge; addr=0, wr_count=0; the next press writes to addr 0.
